// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector sequencer and detector benches.
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_LEN_W = 5;
   localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left-on-enable register presenting its MSB as the serial bit.
module piso_shreg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             shift,
   output logic             msb
);

   logic [WIDTH-1:0] sh_reg;

   // Load has priority so a new run always starts from a fresh word.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         sh_reg <= '0;
      end else if (load) begin
         sh_reg <= din;
      end else if (shift) begin
         sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = sh_reg[WIDTH-1];

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Feeds a test word MSB-first into a serial sequence detector on each tick,
// counting the detector's z pulses and flagging completion.
module seq_det_stream_ctrl
   import seq_det_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LEN_W = DEF_LEN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             tick,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [LEN_W-1:0] len,
   input  logic             z_in,
   output logic             w_out,
   output logic             det_rst_n,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] det_count
);

   localparam logic [LEN_W:0] WIDTH_L = (LEN_W+1)'(WIDTH);

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] remaining_reg;
   logic             first_reg;
   logic [CNT_W-1:0] det_count_reg;
   logic             done_reg;
   logic             len_ok;
   logic             accept;
   logic             sh_msb;
   logic [CNT_W-1:0] count_inc;

   assign len_ok = (len != '0) && ({1'b0, len} <= WIDTH_L);
   assign accept = (state_reg == ST_IDLE) && start && len_ok;

   // Saturating add of the detector's z for the bit that just completed.
   assign count_inc = (z_in && (det_count_reg != {CNT_W{1'b1}})) ?
                      det_count_reg + CNT_W'(1) : det_count_reg;

   piso_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk   (clk),
      .rest  (rest),
      .load  (accept),
      .din   (data_in),
      .shift ((state_reg == ST_SHIFT) && tick),
      .msb   (sh_msb)
   );

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = ST_CLEAR;
         ST_CLEAR: if (tick) state_next = ST_SHIFT;
         ST_SHIFT: if (tick && (remaining_reg == LEN_W'(1))) state_next = ST_DRAIN;
         ST_DRAIN: if (tick) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // The first SHIFT tick skips counting: z then still reflects the reset detector.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         remaining_reg <= '0;
         first_reg     <= 1'b0;
         det_count_reg <= '0;
         done_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  det_count_reg <= '0;
                  done_reg      <= !len_ok;
                  if (len_ok) begin
                     remaining_reg <= len;
                     first_reg     <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  first_reg     <= 1'b0;
                  remaining_reg <= remaining_reg - LEN_W'(1);
                  if (!first_reg) det_count_reg <= count_inc;
               end
            end
            ST_DRAIN: begin
               if (tick) begin
                  det_count_reg <= count_inc;
                  done_reg      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state_reg != ST_IDLE);
      w_out     = (state_reg == ST_SHIFT) ? sh_msb : 1'b0;
      det_rst_n = rest && (state_reg != ST_CLEAR);
      done      = done_reg;
      det_count = det_count_reg;
   end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Scoreboard bench: sequencer driving a behavioural Moore 10010 detector on tick.
module tb_seq_det_stream_ctrl;

   localparam int WIDTH = 16;
   localparam int LEN_W = 5;
   localparam int CNT_W = 2;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rest = 1'b0;
   logic             tick = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [LEN_W-1:0] len = '0;
   logic             z_in;
   logic             w_out, det_rst_n, busy, done;
   logic [CNT_W-1:0] det_count;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      int               cnt;
      int               ticks;
      logic [WIDTH-1:0] data;
      int               len;
      int               t0;
   } exp_t;

   exp_t exp_q[$];

   seq_det_stream_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rest      (rest),
      .tick      (tick),
      .start     (start),
      .data_in   (data_in),
      .len       (len),
      .z_in      (z_in),
      .w_out     (w_out),
      .det_rst_n (det_rst_n),
      .busy      (busy),
      .done      (done),
      .det_count (det_count)
   );

   always #5 clk = ~clk;

   // tick: one clock in four, changed just after the edge
   int ph = 0;
   always @(posedge clk) begin
      #1;
      ph   = (ph + 1) % 4;
      tick = (ph == 0);
   end

   int tick_edges = 0;
   always @(posedge clk) if (tick) tick_edges++;

   // Moore 10010 detector: remembers the last five bits it consumed
   logic [4:0] hist = '0;
   int         nb   = 0;
   always @(posedge clk) begin
      if (!det_rst_n) begin
         hist <= '0;
         nb   <= 0;
      end else if (tick) begin
         hist <= {hist[3:0], w_out};
         nb   <= nb + 1;
      end
   end
   assign z_in = (nb >= 5) && (hist == 5'b10010);

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_count(input logic [WIDTH-1:0] d, input int n);
      logic [4:0] pat;
      int c;
      pat = 5'b10010;
      c   = 0;
      for (int i = 0; i + 5 <= n; i++) begin
         bit m;
         m = 1'b1;
         for (int k = 0; k < 5; k++)
            if (d[WIDTH-1-i-k] != pat[4-k]) m = 1'b0;
         if (m) c++;
      end
      return (c > SAT) ? SAT : c;
   endfunction

   function automatic bit len_valid(input int n);
      return (n >= 1) && (n <= WIDTH);
   endfunction

   // Monitor: collects serial bits during busy ticks, checks each completed run
   logic prev_done = 1'b0;
   logic bits[$];
   exp_t e;
   always @(negedge clk) begin
      if (!rest) begin
         bits.delete();
         prev_done = 1'b0;
      end else begin
         if (busy && tick) bits.push_back(w_out);
         if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("det_count", int'(det_count), e.cnt);
               chk("latency_ticks", tick_edges - e.t0, e.ticks);
               if (len_valid(e.len)) begin
                  chk("busy_ticks", bits.size(), e.len + 2);
                  if (bits.size() == e.len + 2)
                     for (int i = 0; i < e.len; i++)
                        chk("w_out_bit", int'(bits[i+1]), int'(e.data[WIDTH-1-i]));
               end else begin
                  chk("invalid_busy_ticks", bits.size(), 0);
               end
               $display("run data=%h len=%0d det_count=%0d expected=%0d",
                        e.data, e.len, det_count, e.cnt);
            end
            bits.delete();
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [WIDTH-1:0] d, input int n);
      exp_t x;
      @(negedge clk);
      data_in = d;
      len     = LEN_W'(n);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      x.data  = d;
      x.len   = n;
      x.cnt   = len_valid(n) ? model_count(d, n) : 0;
      x.ticks = len_valid(n) ? n + 2 : 0;
      x.t0    = tick_edges;
      exp_q.push_back(x);
      if (len_valid(n)) begin
         chk("busy_after_start", int'(busy), 1);
         chk("done_cleared", int'(done), 0);
      end else begin
         chk("invalid_busy", int'(busy), 0);
         chk("invalid_det_rst_n", int'(det_rst_n), 1);
         chk("invalid_done", int'(done), 1);
      end
   endtask

   task automatic wait_done(input int exp_cnt);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (!busy && done) ok = 1'b1;
      end
      chk("done_within_budget", int'(ok), 1);
      repeat (6) @(negedge clk);
      chk("done_sticky", int'(done), 1);
      chk("count_held", int'(det_count), exp_cnt);
   endtask

   task automatic run(input logic [WIDTH-1:0] d, input int n);
      issue(d, n);
      wait_done(len_valid(n) ? model_count(d, n) : 0);
   endtask

   task automatic wait_ticks(input int n);
      int t;
      t = tick_edges;
      for (int i = 0; i < 200 && tick_edges < t + n; i++) @(negedge clk);
      chk("tick_wait_budget", int'(tick_edges >= t + n), 1);
   endtask

   initial begin
      logic [WIDTH-1:0] d;
      int               n;

      repeat (3) @(negedge clk);
      chk("rst_w_out", int'(w_out), 0);
      chk("rst_det_rst_n", int'(det_rst_n), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_det_count", int'(det_count), 0);
      rest = 1'b1;
      repeat (2) @(negedge clk);

      run(16'h0000, 0);                  // invalid length
      run(16'h9200, 8);                  // 10010010: overlapping matches
      run(16'hFFFF, 16);                 // no match, full length
      run(16'h9000, 5);                  // match on the last bit
      run(16'h9249, 16);                 // four matches, saturates

      // start while busy is ignored
      issue(16'h9200, 8);
      wait_ticks(4);
      @(negedge clk);
      data_in = 16'hFFFF;
      len     = LEN_W'(16);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      wait_done(2);

      // reset mid-shift aborts the run
      issue(16'h9200, 8);
      wait_ticks(4);
      @(negedge clk);
      rest = 1'b0;
      #1;
      chk("abort_w_out", int'(w_out), 0);
      chk("abort_det_rst_n", int'(det_rst_n), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_det_count", int'(det_count), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rest = 1'b1;
      run(16'h1234, 31);                 // length beyond WIDTH
      run(16'h9200, 8);

      for (int r = 0; r < 20; r++) begin
         d = WIDTH'($urandom_range(0, 65535));
         if ($urandom_range(0, 2) == 0) d = d ^ (16'h9249 << $urandom_range(0, 3));
         n = $urandom_range(1, WIDTH);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         run(d, n);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
